serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/digit_adder.sv | 29 ++
 rtl/serial_adder.sv | 139 +++++++++++++
 tb/tb_serial_adder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the digit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDigit = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from full-adder cells.
module digit_adder #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             msb_cin
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[DIGIT];
  // Carry into the top bit feeds the signed-overflow test.
  assign msb_cin = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB first, with
// valid/ready handshakes on both operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DIGIT = DefDigit
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NDIG = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (WIDTH == 0 || DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] da, db, ds;
  logic             dcout, dmsb;
  logic             last;

  // Operand digit select driven by the digit counter.
  always_comb begin
    da = '0;
    db = '0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) begin
        da = a_q[k*DIGIT +: DIGIT];
        db = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .a      (da),
    .b      (db),
    .cin    (carry_q),
    .s      (ds),
    .cout   (dcout),
    .msb_cin(dmsb)
  );

  assign last = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          // Subtraction is a + ~b + 1.
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int unsigned k = 0; k < NDIG; k++) begin
          if (cnt_q == CW'(k)) sum_d[k*DIGIT +: DIGIT] = ds;
        end
        carry_d = dcout;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          cout_d  = dcout;
          ovf_d   = dcout ^ dmsb;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench: three serial_adder configurations (16/4, 8/8, 8/1).
module tb_serial_adder;

  typedef struct {
    int          dut;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid, out_ready, cin_v, sub_v;
  logic [15:0] a_v[3];
  logic [15:0] b_v[3];
  logic [2:0]  in_ready, out_valid, cout, ovf, busy;
  logic [15:0] sum0;
  logic [7:0]  sum1, sum2;

  exp_t sb[$];
  int   acc_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   ncyc  = 0;
  logic [2:0] ov_prev = 3'b000;
  int   ndig[3] = '{4, 1, 8};

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .sum(sum0), .cout(cout[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1), .cout(cout[1]),
    .ovf(ovf[1]), .busy(busy[1])
  );

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_v[2][7:0]), .b(b_v[2][7:0]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum2), .cout(cout[2]),
    .ovf(ovf[2]), .busy(busy[2])
  );

  function automatic logic [15:0] sum_of(int d);
    case (d)
      0:       return sum0;
      1:       return {8'h00, sum1};
      default: return {8'h00, sum2};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // 8-bit reference: a + (sub ? ~b : b) + (sub ? 1 : cin).
  function automatic exp_t model8(int d, logic [7:0] av, logic [7:0] bv, logic ci, logic su);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] f;
    bb     = su ? ~bv : bv;
    f      = {1'b0, av} + {1'b0, bb} + {8'h00, (su ? 1'b1 : ci)};
    e.dut  = d;
    e.sum  = {8'h00, f[7:0]};
    e.cout = f[8];
    e.ovf  = (av[7] == bb[7]) && (f[7] != av[7]);
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    ncyc++;
    for (int d = 0; d < 3; d++) begin
      if (in_valid[d] && in_ready[d]) acc_q.push_back(ncyc);
      if (out_valid[d] && !ov_prev[d]) begin
        if (acc_q.size() == 0) begin
          fail($sformatf("unexpected_out_valid_dut%0d", d));
        end else begin
          lat = ncyc - acc_q.pop_front() - 1;
          check($sformatf("latency_dut%0d", d), lat, ndig[d]);
        end
      end
      if (out_valid[d] && out_ready[d]) begin
        if (sb.size() == 0) begin
          fail($sformatf("result_without_request_dut%0d", d));
        end else begin
          e = sb.pop_front();
          check($sformatf("dut_id_dut%0d", d), d, e.dut);
          check($sformatf("sum_dut%0d", d), sum_of(d), e.sum);
          check($sformatf("cout_dut%0d", d), cout[d], e.cout);
          check($sformatf("ovf_dut%0d", d), ovf[d], e.ovf);
        end
      end
    end
    ov_prev <= out_valid;
  end

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(int d, logic [15:0] av, logic [15:0] bv, logic ci, logic su, exp_t e);
    int t = 0;
    while (!in_ready[d] && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready[d]) begin
      fail($sformatf("in_ready_timeout_dut%0d", d));
      return;
    end
    a_v[d]      = av;
    b_v[d]      = bv;
    cin_v[d]    = ci;
    sub_v[d]    = su;
    in_valid[d] = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  function automatic exp_t mk(int d, logic [15:0] s, logic c, logic o);
    exp_t e;
    e.dut = d; e.sum = s; e.cout = c; e.ovf = o;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    logic [7:0] ra, rb;
    logic       rc, rs;

    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = 3'b111;
    cin_v     = '0;
    sub_v     = '0;
    for (int d = 0; d < 3; d++) begin a_v[d] = '0; b_v[d] = '0; end

    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_sum_dut%0d", d), sum_of(d), 0);
      check($sformatf("rst_out_valid_dut%0d", d), out_valid[d], 0);
      check($sformatf("rst_busy_dut%0d", d), busy[d], 0);
      check($sformatf("rst_cout_ovf_dut%0d", d), {cout[d], ovf[d]}, 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 3'b111);

    // Directed 16-bit vectors with hand-computed results.
    issue(0, 16'h1234, 16'h0FF0, 1'b0, 1'b0, mk(0, 16'h2224, 1'b0, 1'b0));
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(0, 16'h0000, 1'b1, 1'b0));
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(0, 16'h8000, 1'b0, 1'b1));
    issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, mk(0, 16'hFFFE, 1'b0, 1'b0));
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, mk(0, 16'h7FFF, 1'b1, 1'b1));
    issue(0, 16'h00FF, 16'h0F00, 1'b1, 1'b0, mk(0, 16'h1000, 1'b0, 1'b0));
    drain();

    // Hold the result with out_ready low; a stray in_valid must be ignored.
    out_ready[0] = 1'b0;
    issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, mk(0, 16'h3333, 1'b0, 1'b0));
    t = 0;
    while (!out_valid[0] && t < 50) begin @(posedge clk); #1; t++; end
    check("bp_out_valid_seen", out_valid[0], 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid_held", out_valid[0], 1);
      check("bp_sum_stable", sum0, 16'h3333);
      check("bp_in_ready_low", in_ready[0], 0);
      if (i == 3) begin
        a_v[0] = 16'hAAAA; b_v[0] = 16'h5555; sub_v[0] = 1'b1; in_valid[0] = 1'b1;
      end
      if (i == 6) in_valid[0] = 1'b0;
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    drain();
    @(posedge clk); #1;
    check("idle_retains_sum", sum0, 16'h3333);
    check("idle_in_ready", in_ready[0], 1);

    // Reset in the middle of RUN, after digit 2 has been written.
    issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, mk(0, 16'h5555, 1'b0, 1'b0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_sum", sum0, 0);
    check("midrun_rst_out_valid", out_valid[0], 0);
    check("midrun_rst_busy", busy[0], 0);
    check("midrun_rst_cout_ovf", {cout[0], ovf[0]}, 0);
    void'(sb.pop_back());
    acc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("no_result_after_abort", out_valid[0], 0);
    end
    issue(0, 16'h0001, 16'h0001, 1'b0, 1'b0, mk(0, 16'h0002, 1'b0, 1'b0));
    drain();

    // Random vectors for the 8/8 and 8/1 configurations.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        issue(d, {8'h00, ra}, {8'h00, rb}, rc, rs, model8(d, ra, rb, rc, rs));
      end
      drain();
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 0);
    check("accept_queue_empty", acc_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
